// File: rtl/apb_slave_regfile.sv
// APB4 completer register bank: ID register at index 0, byte-strobe writable
// registers above it, programmable wait states and error responses.
module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    input  logic [2:0]  PROT,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int          IW   = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          wr_q;
    logic          err_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;
    logic [31:0]   regs [NUM_REGS];

    logic [31:0]   off;
    logic [IW-1:0] idx;
    logic          setup_err;
    logic          done;
    logic [31:0]   rdval;
    logic          unused_prot;

    assign off         = PADDR - BASE_ADDR;
    assign idx         = off[IW+1:2];
    assign unused_prot = ^PROT[2:1];

    // Error is decided once at setup from the live bus, then held
    always_comb begin
        setup_err = 1'b0;
        if (off[1:0] != 2'b00)
            setup_err = 1'b1;
        if ((PADDR < BASE_ADDR) || (off >= SPAN))
            setup_err = 1'b1;
        if (PWRITE && ((idx == '0) || !PROT[0]))
            setup_err = 1'b1;
    end

    assign done  = (state == ACCESS) && PSEL && (cnt == 4'd0);
    assign rdval = (idx_q == '0) ? ID_VALUE : regs[idx_q];

    assign PREADY  = done;
    assign PSLVERR = done && err_q;
    assign PRDATA  = (done && !wr_q && !err_q) ? rdval : 32'h0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            strb_q  <= 4'h0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        wr_q    <= PWRITE;
                        err_q   <= setup_err;
                        idx_q   <= idx;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        if (wr_q && !err_q) begin
                            for (int b = 0; b < 4; b++)
                                if (strb_q[b])
                                    regs[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 3 and 2 wait states)
// share the bus; expected responses are queued and popped on PREADY.
module tb_apb_slave_regfile;

    logic        PCLK;
    logic        PRESETn;
    logic        psel0, psel1, psel2;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  prot;
    logic [31:0] rd0, rd1, rd2;
    logic        rdy0, rdy1, rdy2;
    logic        er0, er1, er2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb[$];

    apb_slave_regfile #(.WAIT_STATES(0)) u0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PROT(prot), .PRDATA(rd0), .PREADY(rdy0), .PSLVERR(er0)
    );

    apb_slave_regfile #(.WAIT_STATES(3)) u3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PROT(prot), .PRDATA(rd1), .PREADY(rdy1), .PSLVERR(er1)
    );

    apb_slave_regfile #(.WAIT_STATES(2)) u2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel2), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PROT(prot), .PRDATA(rd2), .PREADY(rdy2), .PSLVERR(er2)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? er0 : (d == 1) ? er1 : er2;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
    endfunction

    task automatic select(input int d);
        psel0 = (d == 0);
        psel1 = (d == 1);
        psel2 = (d == 2);
    endtask

    task automatic idle();
        @(negedge PCLK);
        select(-1);
        penable = 1'b0;
    endtask

    task automatic drive_setup(input int d, input logic wr,
                               input logic [31:0] addr,
                               input logic [31:0] data,
                               input logic [3:0] strb,
                               input logic [2:0] pr);
        @(negedge PCLK);
        select(d);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        prot    = pr;
    endtask

    // Full transfer; the expectation is queued before the bus is driven.
    task automatic xfer(input int d, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] pr,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_waits, input string name);
        exp_t e;
        int   w;
        logic got;
        e.rd = exp_rd;
        e.err = exp_err;
        e.waits = exp_waits;
        sb.push_back(e);
        drive_setup(d, wr, addr, data, strb, pr);
        @(negedge PCLK);
        penable = 1'b1;
        #1;
        w = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (get_rdy(d)) begin
                got = 1'b1;
                break;
            end
            if (get_rd(d) !== 32'h0 || get_err(d) !== 1'b0) begin
                $display("FAIL %s wait-cycle outputs rdata=%h err=%b need 0/0",
                         name, get_rd(d), get_err(d));
                errors++;
            end
            w++;
            @(negedge PCLK);
            #1;
        end
        e = sb.pop_front();
        checks++;
        if (!got) begin
            $display("FAIL %s timeout: no PREADY within 20 cycles", name);
            errors++;
        end else begin
            if (get_rd(d) !== e.rd) begin
                $display("FAIL %s rdata got %h need %h", name, get_rd(d), e.rd);
                errors++;
            end
            checks++;
            if (get_err(d) !== e.err) begin
                $display("FAIL %s pslverr got %b need %b", name, get_err(d), e.err);
                errors++;
            end
            checks++;
            if (w != e.waits) begin
                $display("FAIL %s wait cycles got %0d need %0d", name, w, e.waits);
                errors++;
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_rdy(d) !== 1'b0 || get_err(d) !== 1'b0 || get_rd(d) !== 32'h0) begin
                $display("FAIL %s dut%0d rdy=%b err=%b rdata=%h need 0/0/0",
                         name, d, get_rdy(d), get_err(d), get_rd(d));
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        select(-1);
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        prot    = 3'b000;
        repeat (3) @(negedge PCLK);
        check_idle_outputs("reset");
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_id_read();
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b001, 32'hA9B0_0001, 1'b0, 0, "id_read");
        idle();
        xfer(0, 1'b0, 32'h3C, 32'h0, 4'hF, 3'b001, 32'h0, 1'b0, 0, "last_reg_read");
        idle();
    endtask

    task automatic test_strobe_write();
        xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'b0101, 3'b001, 32'h0, 1'b0, 0, "strb_write");
        idle();
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, 32'h00AD_00EF, 1'b0, 0, "strb_read");
        idle();
        xfer(0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 3'b001, 32'h0, 1'b0, 0, "strb_zero_write");
        idle();
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 3'b001, 32'h00AD_00EF, 1'b0, 0, "strb_zero_read");
        idle();
    endtask

    task automatic test_wait_states();
        int t0;
        t0 = int'($time);
        xfer(1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 3'b001, 32'h0, 1'b0, 3, "ws3_write");
        checks++;
        // setup at t0+10, completion sampled 1ns into the 5th cycle
        if (int'($time) - t0 != 51) begin
            $display("FAIL ws3_duration got %0d ns need 51", int'($time) - t0);
            errors++;
        end
        idle();
        xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, 32'h1234_5678, 1'b0, 3, "ws3_read");
        idle();
    endtask

    task automatic test_errors();
        xfer(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1, 0, "err_range");
        idle();
        xfer(0, 1'b1, 32'h5, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1, 0, "err_unaligned");
        idle();
        xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1, 0, "err_reg0");
        idle();
        xfer(0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, 1'b1, 0, "err_unpriv");
        idle();
        xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b001, 32'h0, 1'b1, 0, "err_read_range");
        idle();
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 3'b001, 32'h00AD_00EF, 1'b0, 0, "err_unchanged");
        idle();
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b001, 32'hA9B0_0001, 1'b0, 0, "err_id_intact");
        idle();
    endtask

    task automatic test_unpriv_read();
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 32'h00AD_00EF, 1'b0, 0, "unpriv_read");
        idle();
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 32'hC, 32'h1, 4'hF, 3'b001, 32'h0, 1'b0, 0, "b2b_write");
        xfer(0, 1'b0, 32'hC, 32'h0, 4'hF, 3'b001, 32'h1, 1'b0, 0, "b2b_read");
        xfer(1, 1'b1, 32'hC, 32'h0000_00A5, 4'h1, 3'b001, 32'h0, 1'b0, 3, "b2b_ws_write");
        xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, 3'b001, 32'h0000_00A5, 1'b0, 3, "b2b_ws_read");
        idle();
    endtask

    task automatic test_abort();
        drive_setup(2, 1'b1, 32'h10, 32'hCAFE_0000, 4'hF, 3'b001);
        @(negedge PCLK);
        penable = 1'b1;
        #1;
        checks++;
        if (rdy2 !== 1'b0) begin
            $display("FAIL abort_wait rdy got %b need 0", rdy2);
            errors++;
        end
        @(negedge PCLK);
        select(-1);
        penable = 1'b0;
        #1;
        checks++;
        if (rdy2 !== 1'b0) begin
            $display("FAIL abort_drop rdy got %b need 0", rdy2);
            errors++;
        end
        repeat (4) @(negedge PCLK);
        xfer(2, 1'b0, 32'h10, 32'h0, 4'hF, 3'b001, 32'h0, 1'b0, 2, "abort_readback");
        idle();
    endtask

    task automatic test_reset_mid();
        drive_setup(0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 3'b001);
        @(negedge PCLK);
        penable = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b1) begin
            $display("FAIL rst_mid_complete rdy got %b need 1", rdy0);
            errors++;
        end
        PRESETn = 1'b0;
        #1;
        check_idle_outputs("rst_mid_outputs");
        @(negedge PCLK);
        select(-1);
        penable = 1'b0;
        PRESETn = 1'b1;
        @(negedge PCLK);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 3'b001, 32'h0, 1'b0, 0, "rst_mid_reg1");
        idle();
        xfer(0, 1'b0, 32'hC, 32'h0, 4'hF, 3'b001, 32'h0, 1'b0, 0, "rst_mid_reg3");
        idle();
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b001, 32'hA9B0_0001, 1'b0, 0, "rst_mid_id");
        idle();
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_strobe_write();
        test_wait_states();
        test_errors();
        test_unpriv_read();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB4 completer register bank. It sits directly downstream of the AHB-Lite-to-APB bridge and consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PROT outputs.
- It returns PRDATA/PREADY/PSLVERR to the bridge.
- It provides NUM_REGS 32-bit registers with byte-strobe writes, a read-only ID register, programmable wait states and error responses.
- It is the bridge's standard verification target and the template for APB peripherals.

Parameters:
- BASE_ADDR, 32'h0000_0000, base of the register window (aligned to NUM_REGS*4).
- NUM_REGS, 16, number of 32-bit registers (power of 2, 2..256); register 0 is the ID register.
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..15).
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte strobes; PSTRB[n] enables PWDATA[8n+7:8n].
- PROT  in  3  protection attributes; PROT[0]=1 means privileged.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response.

Behaviour:
- Reset (PRESETn low, asynchronous): state=IDLE, wait counter=0, registers 1..NUM_REGS-1 = 0. PREADY, PSLVERR and PRDATA are all 0 while in reset.
- FSM has two states, IDLE and ACCESS.
- IDLE, when PSEL=1 and PENABLE=0 (setup phase):
  - Latch PWRITE, PADDR, PWDATA, PSTRB and PROT.
  - Compute the error flag.
  - Load counter=WAIT_STATES.
  - Go to ACCESS.
- IDLE, when PENABLE=1 without a preceding setup: ignored and stays in IDLE.
- ACCESS, when PSEL=0: abort. Go to IDLE; no write is performed and no response is given.
- ACCESS, when PSEL=1 and counter!=0: PREADY=0 and counter decrements.
- ACCESS, when PSEL=1 and counter==0: PREADY=1 (completion cycle); next state is IDLE.
  - Back-to-back transfers are therefore supported: the next setup phase is the cycle after completion.
  - Latency: access phase is WAIT_STATES+1 cycles; a full transfer is WAIT_STATES+2 cycles.
- PREADY is decoded combinationally from the registered state and counter, and is 0 outside the completion cycle.
- Error flag is set if any of the following holds:
  - PADDR[1:0]!=0 (unaligned);
  - PADDR is outside [BASE_ADDR, BASE_ADDR+NUM_REGS*4-1];
  - write to register 0;
  - write with PROT[0]=0 (unprivileged).
  - Unprivileged reads are allowed.
- PSLVERR equals the error flag only in the completion cycle; otherwise 0.
- Write commit happens at the rising edge ending the completion cycle, only if the error flag is clear.
  - Register index = (PADDR-BASE_ADDR)>>2.
  - Each byte lane is updated only where PSTRB is 1.
  - PSTRB=0 is a legal no-op write with no error.
- Read: PRDATA holds the register value in the completion cycle (register 0 = ID_VALUE). PRDATA=0 in every other cycle and on error reads.
- PSTRB is ignored on reads.
- Latched setup values are used for the entire access phase; changes to the inputs during ACCESS have no effect (the bridge must hold them stable).
- Reset asserted mid-transfer: the transfer is abandoned, no partial write occurs, and registers take their reset values.

Test Plan:
- Reset, then read reg0 with WAIT_STATES=0 -> PREADY=1 in the first access cycle, PRDATA=32'hA9B0_0001, PSLVERR=0.
- Privileged write 32'hDEAD_BEEF to BASE+4 with PSTRB=4'b0101, then read BASE+4 -> readback 32'h00AD_00EF.
- WAIT_STATES=3, write then read BASE+8 -> PREADY low for exactly 3 access cycles then high; each transfer takes 5 PCLK cycles; data correct.
- Error cases, each returning PSLVERR=1 with PREADY=1 and registers unchanged:
  - write to BASE+0x40 (NUM_REGS=16, out of range);
  - write to BASE+5 (unaligned);
  - write to reg0;
  - write with PROT=3'b000.
- Unprivileged read of BASE+4 -> PSLVERR=0 with correct data.
- Back-to-back write BASE+12 = 1 then read BASE+12 with no idle cycle between -> read returns 1.
- Abort: PSEL dropped mid-access (WAIT_STATES=2) -> FSM returns to IDLE and the register is unchanged.
- PRESETn pulsed low during a write access phase -> outputs 0 immediately and the register reads 0 afterwards.
